// File: rtl/alu_execute_stage.sv
// Execute/writeback stage for a 2-read/1-write register file: reads two operands,
// computes one ALU result (MUL by iterative shift-add) and writes it back via port A.
module alu_execute_stage #(
    parameter int AddressWidth  = 6,
    parameter int RegisterWidth = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [3:0]               Opcode,
    input  logic [AddressWidth-1:0]  DestAddress,
    input  logic [AddressWidth-1:0]  SourceAddressA,
    input  logic [AddressWidth-1:0]  SourceAddressB,
    input  logic [RegisterWidth-1:0] Immediate,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Illegal,
    output logic                     ZeroFlag,
    output logic                     CarryFlag,
    output logic [AddressWidth-1:0]  AddressA,
    output logic [AddressWidth-1:0]  AddressB,
    input  logic [RegisterWidth-1:0] ReadDataA,
    input  logic [RegisterWidth-1:0] ReadDataB,
    output logic                     WriteEnable,
    output logic [RegisterWidth-1:0] WriteData
);

    localparam int ShiftWidth = $clog2(RegisterWidth);
    localparam logic [ShiftWidth-1:0] LastIter = ShiftWidth'(RegisterWidth - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_PASS = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd9;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITEBACK} state_t;

    state_t state_reg, state_next;

    logic [3:0]               opcode_reg;
    logic [AddressWidth-1:0]  dest_reg;
    logic [AddressWidth-1:0]  src_a_reg;
    logic [AddressWidth-1:0]  src_b_reg;
    logic [RegisterWidth-1:0] imm_reg;
    logic [RegisterWidth-1:0] operand_a_reg;
    logic [RegisterWidth-1:0] operand_b_reg;
    logic [RegisterWidth-1:0] result_reg;
    logic                     carry_reg;
    logic [ShiftWidth-1:0]    iter_reg;
    logic                     zero_flag_reg;
    logic                     carry_flag_reg;

    logic                     illegal_op;
    logic                     is_mul;
    logic                     mul_last;
    logic [RegisterWidth:0]   sum;
    logic [RegisterWidth-1:0] alu_result;
    logic                     alu_carry;
    logic [RegisterWidth-1:0] mul_acc_next;

    assign illegal_op = (opcode_reg > OP_LDI);
    assign is_mul     = (opcode_reg == OP_MUL);
    assign mul_last   = (iter_reg == LastIter);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (Start) state_next = READ;
            READ:      state_next = EXEC;
            EXEC:      if (!is_mul || mul_last) state_next = WRITEBACK;
            WRITEBACK: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign sum = {1'b0, operand_a_reg} + {1'b0, operand_b_reg};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (opcode_reg)
            OP_ADD: begin
                alu_result = sum[RegisterWidth-1:0];
                alu_carry  = sum[RegisterWidth];
            end
            OP_SUB: begin
                alu_result = operand_a_reg - operand_b_reg;
                alu_carry  = (operand_a_reg < operand_b_reg);
            end
            OP_AND:  alu_result = operand_a_reg & operand_b_reg;
            OP_OR:   alu_result = operand_a_reg | operand_b_reg;
            OP_XOR:  alu_result = operand_a_reg ^ operand_b_reg;
            OP_PASS: alu_result = operand_a_reg;
            OP_SHL:  alu_result = operand_a_reg << operand_b_reg[ShiftWidth-1:0];
            OP_SHR:  alu_result = operand_a_reg >> operand_b_reg[ShiftWidth-1:0];
            OP_LDI:  alu_result = imm_reg;
            default: alu_result = '0;
        endcase
    end

    // Shift-add: the multiplicand walks left and the multiplier walks right in place.
    assign mul_acc_next = result_reg + (operand_b_reg[0] ? operand_a_reg : '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            opcode_reg     <= '0;
            dest_reg       <= '0;
            src_a_reg      <= '0;
            src_b_reg      <= '0;
            imm_reg        <= '0;
            operand_a_reg  <= '0;
            operand_b_reg  <= '0;
            result_reg     <= '0;
            carry_reg      <= 1'b0;
            iter_reg       <= '0;
            zero_flag_reg  <= 1'b0;
            carry_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        opcode_reg <= Opcode;
                        dest_reg   <= DestAddress;
                        src_a_reg  <= SourceAddressA;
                        src_b_reg  <= SourceAddressB;
                        imm_reg    <= Immediate;
                    end
                end
                READ: begin
                    operand_a_reg <= ReadDataA;
                    operand_b_reg <= ReadDataB;
                    result_reg    <= '0;
                    carry_reg     <= 1'b0;
                    iter_reg      <= '0;
                end
                EXEC: begin
                    if (is_mul) begin
                        result_reg    <= mul_acc_next;
                        operand_a_reg <= operand_a_reg << 1;
                        operand_b_reg <= operand_b_reg >> 1;
                        iter_reg      <= iter_reg + 1'b1;
                        carry_reg     <= 1'b0;
                    end else begin
                        result_reg <= alu_result;
                        carry_reg  <= alu_carry;
                    end
                end
                WRITEBACK: begin
                    if (!illegal_op) begin
                        zero_flag_reg  <= (result_reg == '0);
                        carry_flag_reg <= carry_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write strobe is gated by Reset directly so a reset in WRITEBACK suppresses the commit.
    always_comb begin
        AddressA    = '0;
        AddressB    = '0;
        WriteData   = '0;
        WriteEnable = 1'b0;
        case (state_reg)
            READ: begin
                AddressA = src_a_reg;
                AddressB = src_b_reg;
            end
            WRITEBACK: begin
                AddressA = dest_reg;
                if (!illegal_op) begin
                    WriteData   = result_reg;
                    WriteEnable = ~Reset;
                end
            end
            default: ;
        endcase
    end

    assign Busy      = (state_reg != IDLE);
    assign Done      = (state_reg == WRITEBACK);
    assign Illegal   = (state_reg == WRITEBACK) && illegal_op;
    assign ZeroFlag  = zero_flag_reg;
    assign CarryFlag = carry_flag_reg;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: directed ops push expected writebacks,
// a monitor pops and checks them whenever Done is presented.
module tb_alu_execute_stage;

    localparam int AW = 6;
    localparam int RW = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [3:0]    Opcode = '0;
    logic [AW-1:0] DestAddress = '0;
    logic [AW-1:0] SourceAddressA = '0;
    logic [AW-1:0] SourceAddressB = '0;
    logic [RW-1:0] Immediate = '0;
    logic          Busy, Done, Illegal, ZeroFlag, CarryFlag;
    logic [AW-1:0] AddressA, AddressB;
    logic [RW-1:0] ReadDataA, ReadDataB;
    logic          WriteEnable;
    logic [RW-1:0] WriteData;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic          illegal;
        logic          we;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        logic          check_data;
        logic          carry;
        logic          zero;
    } exp_t;

    exp_t sb_q[$];

    alu_execute_stage #(.AddressWidth(AW), .RegisterWidth(RW)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Opcode(Opcode),
        .DestAddress(DestAddress), .SourceAddressA(SourceAddressA),
        .SourceAddressB(SourceAddressB), .Immediate(Immediate),
        .Busy(Busy), .Done(Done), .Illegal(Illegal),
        .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag),
        .AddressA(AddressA), .AddressB(AddressB),
        .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
        .WriteEnable(WriteEnable), .WriteData(WriteData)
    );

    always #5 Clock = ~Clock;

    // Register file model: combinational reads, synchronous write at AddressA.
    logic [RW-1:0] regs [2**AW];
    logic          rf_clear = 1'b1;

    always @(posedge Clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
        end else if (WriteEnable) begin
            regs[AddressA] <= WriteData;
        end
    end

    assign ReadDataA = regs[AddressA];
    assign ReadDataB = regs[AddressB];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [AW-1:0] d, input logic [AW-1:0] sa,
                          input logic [AW-1:0] sb, input logic [RW-1:0] imm,
                          input logic [RW-1:0] exp_data, input logic exp_c, input logic exp_z,
                          input int exp_busy, input bit glitch);
        exp_t e;
        int   busy_cnt;
        e.illegal    = (op > 4'd9);
        e.we         = !e.illegal;
        e.addr       = d;
        e.data       = e.illegal ? '0 : exp_data;
        e.check_data = 1'b1;
        e.carry      = exp_c;
        e.zero       = exp_z;
        @(negedge Clock);
        Opcode = op; DestAddress = d; SourceAddressA = sa; SourceAddressB = sb;
        Immediate = imm; Start = 1'b1;
        sb_q.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Busy !== 1'b1) break;
            busy_cnt++;
            // Extra requests during EXEC and WRITEBACK must be dropped.
            if (glitch && (i == 1 || i == 2)) begin
                Start = 1'b1; Opcode = 4'd9; DestAddress = 6'd15; Immediate = 16'hBEEF;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clock);
        end
        Start = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    endtask

    // Monitor: one line per writeback transaction; flags checked one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("FAIL unexpected_done: got Done=1 at addr %0d, required no pending op", AddressA);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn dest=%0d we=%b data=%h illegal=%b", AddressA, WriteEnable, WriteData, Illegal);
                    check("wb_illegal", 32'(Illegal), 32'(e.illegal));
                    check("wb_we", 32'(WriteEnable), 32'(e.we));
                    check("wb_addr", 32'(AddressA), 32'(e.addr));
                    if (e.check_data) check("wb_data", 32'(WriteData), 32'(e.data));
                    @(negedge Clock);
                    check("flag_zero", 32'(ZeroFlag), 32'(e.zero));
                    check("flag_carry", 32'(CarryFlag), 32'(e.carry));
                end
            end else if (WriteEnable === 1'b1) begin
                assertions++;
                failures++;
                $display("FAIL spurious_write: got WriteEnable=1 outside WRITEBACK, required 0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);
        check("rst_we", 32'(WriteEnable), 32'd0);
        check("rst_flags", 32'({ZeroFlag, CarryFlag}), 32'd0);
        check("rst_addr", 32'({AddressA, AddressB}), 32'd0);
        check("rst_wdata", 32'(WriteData), 32'd0);
        Reset = 1'b0;
        rf_clear = 1'b0;

        //     op     dest   srcA   srcB   imm       expected  C     Z     busy glitch
        run_op(4'd9,  6'd3,  6'd0,  6'd0,  16'h00FF, 16'h00FF, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd9,  6'd4,  6'd0,  6'd0,  16'h0001, 16'h0001, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd0,  6'd5,  6'd3,  6'd4,  16'h0000, 16'h0100, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd9,  6'd1,  6'd0,  6'd0,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd9,  6'd2,  6'd0,  6'd0,  16'h0001, 16'h0001, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd0,  6'd6,  6'd1,  6'd2,  16'h0000, 16'h0000, 1'b1, 1'b1, 3,   1'b0);
        run_op(4'hF,  6'd20, 6'd1,  6'd2,  16'h0000, 16'h0000, 1'b1, 1'b1, 3,   1'b0);
        run_op(4'd1,  6'd7,  6'd2,  6'd1,  16'h0000, 16'h0002, 1'b1, 1'b0, 3,   1'b1);
        run_op(4'd9,  6'd8,  6'd0,  6'd0,  16'h0123, 16'h0123, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd9,  6'd9,  6'd0,  6'd0,  16'h0004, 16'h0004, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd8,  6'd10, 6'd8,  6'd9,  16'h0000, 16'h048C, 1'b0, 1'b0, 18,  1'b0);
        run_op(4'd6,  6'd11, 6'd8,  6'd9,  16'h0000, 16'h1230, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd7,  6'd16, 6'd8,  6'd9,  16'h0000, 16'h0012, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd2,  6'd17, 6'd8,  6'd3,  16'h0000, 16'h0023, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd3,  6'd18, 6'd8,  6'd9,  16'h0000, 16'h0127, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd4,  6'd19, 6'd1,  6'd8,  16'h0000, 16'hFEDC, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd5,  6'd22, 6'd8,  6'd1,  16'h0000, 16'h0123, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd1,  6'd23, 6'd8,  6'd9,  16'h0000, 16'h011F, 1'b0, 1'b0, 3,   1'b0);
        run_op(4'd0,  6'd24, 6'd3,  6'd1,  16'h0000, 16'h00FE, 1'b1, 1'b0, 3,   1'b0);

        // Reset in the middle of a MUL: no writeback, machine idle right after.
        @(negedge Clock);
        Opcode = 4'd8; DestAddress = 6'd20; SourceAddressA = 6'd1; SourceAddressB = 6'd1; Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("mulrst_busy", 32'(Busy), 32'd0);
        check("mulrst_flags", 32'({ZeroFlag, CarryFlag}), 32'd0);
        Reset = 1'b0;
        run_op(4'd5,  6'd21, 6'd20, 6'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 3,   1'b0);

        // Reset held across the WRITEBACK cycle: Done shows but nothing commits.
        e.illegal = 1'b0; e.we = 1'b0; e.addr = 6'd13; e.data = '0;
        e.check_data = 1'b0; e.carry = 1'b0; e.zero = 1'b0;
        @(negedge Clock);
        Opcode = 4'd0; DestAddress = 6'd13; SourceAddressA = 6'd3; SourceAddressB = 6'd4; Start = 1'b1;
        sb_q.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        run_op(4'd5,  6'd14, 6'd13, 6'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 3,   1'b0);

        // Back-to-back with Start held: second op accepted in the first IDLE cycle.
        e.illegal = 1'b0; e.we = 1'b1; e.addr = 6'd12; e.data = 16'h4000;
        e.check_data = 1'b1; e.carry = 1'b0; e.zero = 1'b0;
        @(negedge Clock);
        Opcode = 4'd9; DestAddress = 6'd12; Immediate = 16'h4000; Start = 1'b1;
        sb_q.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
        for (int i = 0; i < 10; i++) begin
            if (Done === 1'b1) break;
            @(negedge Clock);
        end
        Opcode = 4'd0; DestAddress = 6'd12; SourceAddressA = 6'd12; SourceAddressB = 6'd12;
        e.data = 16'h8000;
        sb_q.push_back(e);
        @(negedge Clock);
        check("b2b_idle_gap", 32'(Busy), 32'd0);
        @(negedge Clock);
        check("b2b_accepted", 32'(Busy), 32'd1);
        Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (Busy !== 1'b1) break;
            @(negedge Clock);
        end

        repeat (5) @(negedge Clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
